bbs_bit_packer: RTL and testbench

- Consumes the serial bit stream of the BBS generator (`out_valid`/`out_bit`) and packs every W consecutive bits into one W-bit word.
- Completed words are buffered in a small FIFO and presented on a ready/valid output port to downstream consumers (entropy sink, host readout).
- A `flush` input, driven from the generator's `reseed` pulse, discards any partially assembled word, so no word ever mixes bits from two seeds.

---
 rtl/bbs_pkg.sv | 18 +
 rtl/bbs_word_fifo.sv | 75 +++++++
 rtl/bbs_bit_packer.sv | 120 ++++++++++++
 tb/tb_bbs_bit_packer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bbs_pkg.sv
// Shared constants and helpers for the BBS random bit pipeline.
package bbs_pkg;

    // Default output word width of the packer.
    localparam int BBS_W = 16;

    // Default Blum Blum Shub modulus used by the generator.
    localparam int BBS_M = 21209;

    // Word type at the default width.
    typedef logic [BBS_W-1:0] bbs_word_t;

    // Width needed to index n items; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bbs_word_fifo.sv
// Small word FIFO: synchronous push/pop, async active-high reset.
// Full/empty come from an occupancy counter one bit wider than the pointers.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is ignored and the caller accounts for the lost word.
module bbs_word_fifo
    import bbs_pkg::*;
#(
    parameter int W     = BBS_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = cnt_width(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    // Head reads as zero while empty so the output is clean after reset.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally.
    always_comb begin
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/bbs_bit_packer.sv
// Packs the serial BBS bit stream MSB-first into W-bit words and buffers
// them for a ready/valid consumer. A flush drops the partial word so no
// word mixes bits from two seeds. Lost words are tracked by a sticky flag
// and a saturating counter.
//
// Output handshake: out_valid means out_word holds the FIFO head; a word
// transfers on any rising edge where out_valid and out_ready are both 1.
// While out_valid=1 and out_ready=0 the word is held; out_ready is ignored
// while empty, and a freshly pushed word is never bypassed to the output.
module bbs_bit_packer
    import bbs_pkg::*;
#(
    parameter int W     = BBS_W,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 flush,
    input  logic                 out_ready,
    input  logic                 clr_err,
    output logic                 out_valid,
    output logic [W-1:0]         out_word,
    output logic [$clog2(W)-1:0] bit_cnt,
    output logic                 overflow,
    output logic [CW-1:0]        drop_cnt
);

    localparam int BW = cnt_width(W);

    logic [W-1:0]  acc_q, acc_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic          accept;
    logic          complete;
    logic [W-1:0]  word_next;
    logic          pop;
    logic          drop;
    logic          fifo_full;
    logic          fifo_empty;

    assign out_valid = !fifo_empty;
    assign bit_cnt   = bit_cnt_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    // Accumulate bits, detect word completion and update error tracking.
    always_comb begin
        accept     = in_valid && !flush;
        complete   = accept && (bit_cnt_q == BW'(W-1));
        word_next  = {acc_q[W-2:0], in_bit};
        pop        = out_valid && out_ready;
        drop       = complete && fifo_full && !pop;

        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (accept) begin
            acc_d = word_next;
        end

        // Flush beats accept, including on the would-be completing bit.
        if (flush) begin
            bit_cnt_d = '0;
        end else if (complete) begin
            bit_cnt_d = '0;
        end else if (accept) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
        end

        // A drop in the same cycle as a clear leaves a fresh count of one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_err) begin
                drop_cnt_d = CW'(1);
            end else if (drop_cnt_q != {CW{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + CW'(1);
            end
        end else if (clr_err) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    bbs_word_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (complete),
        .pop   (pop),
        .wdata (word_next),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (out_word)
    );

endmodule

// File: tb/tb_bbs_bit_packer.sv
// Directed bench for bbs_bit_packer at W=16, DEPTH=4, CW=8.
module tb_bbs_bit_packer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_bit;
  logic        flush;
  logic        out_ready;
  logic        clr_err;
  logic        out_valid;
  logic [15:0] out_word;
  logic [3:0]  bit_cnt;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int total;
  int bad;
  logic [15:0] exp_q[$];

  bbs_bit_packer #(.W(16), .DEPTH(4), .CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .flush     (flush),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .out_valid (out_valid),
    .out_word  (out_word),
    .bit_cnt   (bit_cnt),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge
  task automatic send_bit(input logic b);
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = b;
    flush    = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
    flush    = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_word !== 16'h0000) begin bad++; $display("FAIL reset_out_word got=%h exp=0000", out_word); end
    total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    send_word(16'hAAAA);
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    total++; if (out_word !== 16'hAAAA) begin bad++; $display("FAIL single_word got=%h exp=aaaa", out_word); end
    total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL single_bit_cnt got=%0d exp=0", bit_cnt); end
    idle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge clk);
    total++; if (bit_cnt !== 4'd5) begin bad++; $display("FAIL flush_pre_cnt got=%0d exp=5", bit_cnt); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(negedge clk);
    total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", bit_cnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_word got=%b exp=0", out_valid); end
    flush    = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b0;
    for (int i = 0; i < 15; i++) send_bit(1'b0);
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_valid got=%b exp=1", out_valid); end
    total++; if (out_word !== 16'h0000) begin bad++; $display("FAIL flush_word got=%h exp=0000", out_word); end
    idle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_one_word got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [15:0] words [6];
    words = '{16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 16'h1111, 16'h2222};
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_word(words[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(words[i]);
    idle();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
    total++; if (out_word !== 16'h1234) begin bad++; $display("FAIL ovf_head got=%h exp=1234", out_word); end
    for (int i = 0; i < 3; i++) idle();
    total++; if (out_word !== 16'h1234) begin bad++; $display("FAIL ovf_hold got=%h exp=1234", out_word); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      total++; if (out_valid !== 1'b1 || out_word !== e) begin bad++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_word, e); end
      @(negedge clk);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [15:0] w;
    @(negedge clk);
    clr_err = 1'b1;
    idle();
    total++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin bad++; $display("FAIL clr got=%b/%0d exp=0/0", overflow, drop_cnt); end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(16'ha001 + 16'(i));
    w = 16'hb00b;
    for (int i = 15; i >= 1; i--) send_bit(w[i]);
    @(negedge clk);
    in_valid  = 1'b1;
    in_bit    = w[0];
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin bad++; $display("FAIL fullpop_nodrop got=%b/%0d exp=0/0", overflow, drop_cnt); end
    exp_q = '{16'ha002, 16'ha003, 16'ha004, 16'hb00b};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      total++; if (out_valid !== 1'b1 || out_word !== e) begin bad++; $display("FAIL fullpop_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_word, e); end
      @(negedge clk);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_clr_and_saturate();
    logic [15:0] w;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(16'hc000 + 16'(i));
    send_word(16'h5555);
    idle();
    total++; if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin bad++; $display("FAIL first_drop got=%b/%0d exp=1/1", overflow, drop_cnt); end
    w = 16'h3c3c;
    for (int i = 15; i >= 1; i--) send_bit(w[i]);
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = w[0];
    clr_err  = 1'b1;
    idle();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_drop_ovf got=%b exp=1", overflow); end
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL clr_drop_cnt got=%0d exp=1", drop_cnt); end
    for (int k = 1; k <= 300; k++) begin
      send_word(16'hffff);
      idle();
      if (k == 253) begin
        total++; if (drop_cnt !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=254", drop_cnt); end
      end
      if (k == 254) begin
        total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=255", drop_cnt); end
      end
    end
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", drop_cnt); end
    total++; if (out_word !== 16'hc000) begin bad++; $display("FAIL sat_head got=%h exp=c000", out_word); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (bit_cnt !== 4'd7) begin bad++; $display("FAIL prereset_cnt got=%0d exp=7", bit_cnt); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
    total++; if (out_word !== 16'h0000) begin bad++; $display("FAIL areset_word got=%h exp=0000", out_word); end
    total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL areset_cnt got=%0d exp=0", bit_cnt); end
    total++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin bad++; $display("FAIL areset_err got=%b/%0d exp=0/0", overflow, drop_cnt); end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    send_word(16'h8001);
    idle();
    total++; if (out_valid !== 1'b1 || out_word !== 16'h8001) begin bad++; $display("FAIL restart_word got=%b/%h exp=1/8001", out_valid, out_word); end
    idle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL restart_pop got=%b exp=0", out_valid); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    test_reset();
    test_single_word();
    test_flush();
    test_overflow();
    test_full_pop();
    test_clr_and_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
